// File: rtl/rf_pkg.sv
// ============================================================================
// rf_pkg : shared types, constants and helpers for the multi-port register file
// Revision 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Port 1 carries the younger result and therefore wins address collisions.
  localparam int WR_PRI_1 = 1;

  localparam int RF_NREG_DEFAULT = 32;
  localparam int RF_AW_DEFAULT   = addr_width(RF_NREG_DEFAULT);

  typedef logic [RF_AW_DEFAULT-1:0] rf_addr_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// rf_scoreboard : per-register pending-write busy bits, double-issue detect
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard import rf_pkg::*; #(
  parameter int NREG     = 32,
  parameter int AW       = addr_width(NREG),
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_busy,
  output logic                dbl_iss
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            dbl_q, dbl_d;
  logic            w_iss_clr;

  assign w_iss_clr = (wr0_en && (wr0_addr == iss_addr)) ||
                     (wr1_en && (wr1_addr == iss_addr));

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if ((wr0_en && (wr0_addr == AW'(i))) || (wr1_en && (wr1_addr == AW'(i))))
        busy_d[i] = 1'b0;
    end
    // Issue is applied after the clears: it is the newer event.
    if (iss_en)
      busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_d[0] = 1'b0;
  end

  always_comb begin
    dbl_d = iss_en && busy_q[iss_addr] && !w_iss_clr;
    if ((ZERO_REG != 0) && (iss_addr == '0))
      dbl_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
      dbl_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      dbl_q  <= dbl_d;
    end
  end

  assign dbl_iss = dbl_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_busy
    logic [AW-1:0] w_addr;
    logic          w_hit;

    assign w_addr = rd_addr[k*AW +: AW];
    assign w_hit  = (wr0_en && (wr0_addr == w_addr)) ||
                    (wr1_en && (wr1_addr == w_addr));

    always_comb begin
      rd_busy[k] = busy_q[w_addr];
      if ((BYPASS != 0) && w_hit)
        rd_busy[k] = 1'b0;
      if ((ZERO_REG != 0) && (w_addr == '0))
        rd_busy[k] = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : NREAD-read / 2-write register file with bypass and scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_mp import rf_pkg::*; #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int AW       = addr_width(NREG),
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*DW-1:0] rd_data,
  output logic [NREAD-1:0]    rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [DW-1:0]       wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [DW-1:0]       wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [AW-1:0]       test_addr,
  output logic [DW-1:0]       test_data,
  output logic                dbl_iss
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  logic          w_hi_en,   w_lo_en;
  logic [AW-1:0] w_hi_addr, w_lo_addr;
  logic [DW-1:0] w_hi_data, w_lo_data;

  assign w_hi_en   = (WR_PRI_1 == 1) ? wr1_en   : wr0_en;
  assign w_hi_addr = (WR_PRI_1 == 1) ? wr1_addr : wr0_addr;
  assign w_hi_data = (WR_PRI_1 == 1) ? wr1_data : wr0_data;
  assign w_lo_en   = (WR_PRI_1 == 1) ? wr0_en   : wr1_en;
  assign w_lo_addr = (WR_PRI_1 == 1) ? wr0_addr : wr1_addr;
  assign w_lo_data = (WR_PRI_1 == 1) ? wr0_data : wr1_data;

  // Low-priority write lands first so a same-address high-priority write overrides it.
  always_comb begin
    mem_d = mem_q;
    if (w_lo_en)
      mem_d[w_lo_addr] = w_lo_data;
    if (w_hi_en)
      mem_d[w_hi_addr] = w_hi_data;
    if (ZERO_REG != 0)
      mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++)
        mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    assign w_addr = rd_addr[k*AW +: AW];

    always_comb begin
      w_data = mem_q[w_addr];
      if (BYPASS != 0) begin
        if (w_hi_en && (w_hi_addr == w_addr))
          w_data = w_hi_data;
        else if (w_lo_en && (w_lo_addr == w_addr))
          w_data = w_lo_data;
      end
      if ((ZERO_REG != 0) && (w_addr == '0))
        w_data = '0;
    end

    assign rd_data[k*DW +: DW] = w_data;
  end

  always_comb begin
    test_data = mem_q[test_addr];
    if ((ZERO_REG != 0) && (test_addr == '0))
      test_data = '0;
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .NREAD    (NREAD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .dbl_iss  (dbl_iss)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp : directed vector table, reset sequences and random model check
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NVEC = 17;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0]    rd_busy, rd_busy_nb;
  logic             wr0_en, wr1_en, iss_en;
  logic [AW-1:0]    wr0_addr, wr1_addr, iss_addr, test_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [DW-1:0]    test_data, test_data_nb;
  logic             dbl_iss, dbl_iss_nb;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]   m_mem [NREG];
  logic [DW-1:0]   n_mem [NREG];
  logic [NREG-1:0] m_busy, n_busy;
  bit              exp_dbl_q[$];

  regfile_mp #(.DW(DW), .NREG(NREG), .NREAD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .test_addr(test_addr),
    .test_data(test_data), .dbl_iss(dbl_iss)
  );

  regfile_mp #(.DW(DW), .NREG(NREG), .NREAD(NR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .test_addr(test_addr),
    .test_data(test_data_nb), .dbl_iss(dbl_iss_nb)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          wr0_en;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr1_en;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] rd0;
    logic [AW-1:0] taddr;
    logic [DW-1:0] exp_rd0;
    logic [DW-1:0] exp_rd0_nb;
    logic [DW-1:0] exp_test;
    logic          exp_busy0;
    logic          exp_dbl;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return 1'b0;
    if (byp && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_busy = '0;
    exp_dbl_q.delete();
  endtask

  task automatic check_comb();
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      chk($sformatf("rd_data[%0d] a=%0d", k, a), rd_data[k*DW +: DW], exp_rd(a, 1'b1));
      chk($sformatf("rd_data_nb[%0d] a=%0d", k, a), rd_data_nb[k*DW +: DW], exp_rd(a, 1'b0));
      chk($sformatf("rd_busy[%0d] a=%0d", k, a), DW'(rd_busy[k]), DW'(exp_busy(a, 1'b1)));
      chk($sformatf("rd_busy_nb[%0d] a=%0d", k, a), DW'(rd_busy_nb[k]), DW'(exp_busy(a, 1'b0)));
    end
    chk("test_data", test_data, (test_addr == '0) ? '0 : m_mem[test_addr]);
    chk("test_data_nb", test_data_nb, (test_addr == '0) ? '0 : m_mem[test_addr]);
  endtask

  // One clock: check combinational outputs, predict the edge, then score dbl_iss.
  task automatic cycle();
    bit e_dbl;
    #1;
    check_comb();
    for (int i = 0; i < NREG; i++) n_mem[i] = m_mem[i];
    n_busy = m_busy;
    if (wr0_en && wr0_addr != '0) begin n_mem[wr0_addr] = wr0_data; n_busy[wr0_addr] = 1'b0; end
    if (wr1_en && wr1_addr != '0) begin n_mem[wr1_addr] = wr1_data; n_busy[wr1_addr] = 1'b0; end
    if (iss_en && iss_addr != '0) n_busy[iss_addr] = 1'b1;
    e_dbl = iss_en && (iss_addr != '0) && m_busy[iss_addr] &&
            !(wr0_en && wr0_addr == iss_addr) && !(wr1_en && wr1_addr == iss_addr);
    exp_dbl_q.push_back(e_dbl);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) m_mem[i] = n_mem[i];
    m_busy = n_busy;
    if (exp_dbl_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL dbl_iss scoreboard: queue empty");
    end else begin
      e_dbl = exp_dbl_q.pop_front();
      chk("dbl_iss", DW'(dbl_iss), DW'(e_dbl));
      chk("dbl_iss_nb", DW'(dbl_iss_nb), DW'(e_dbl));
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk({tag, " rd_data"}, rd_data[k*DW +: DW], '0);
      chk({tag, " rd_data_nb"}, rd_data_nb[k*DW +: DW], '0);
    end
    chk({tag, " rd_busy"}, DW'(rd_busy), '0);
    chk({tag, " rd_busy_nb"}, DW'(rd_busy_nb), '0);
    chk({tag, " test_data"}, test_data, '0);
    chk({tag, " dbl_iss"}, DW'(dbl_iss), '0);
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    iss_en = 0; iss_addr = '0;
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
  endfunction

  initial begin
    vecs[0]  = '{1,7,32'h11111111, 1,7,32'h22222222, 0,0,  7,7,  32'h22222222, 32'h0,        32'h0,        0,0};
    vecs[1]  = '{1,3,32'h33333333, 1,4,32'h44444444, 0,0,  7,7,  32'h22222222, 32'h22222222, 32'h22222222, 0,0};
    vecs[2]  = '{0,0,32'h0,        0,0,32'h0,        0,0,  3,4,  32'h33333333, 32'h33333333, 32'h44444444, 0,0};
    vecs[3]  = '{0,0,32'h0,        1,9,32'h0BAD0009, 0,0,  9,9,  32'h0BAD0009, 32'h0,        32'h0,        0,0};
    vecs[4]  = '{1,9,32'hCAFE0001, 0,0,32'h0,        0,0,  9,9,  32'hCAFE0001, 32'h0BAD0009, 32'h0BAD0009, 0,0};
    vecs[5]  = '{0,0,32'h0,        0,0,32'h0,        0,0,  9,9,  32'hCAFE0001, 32'hCAFE0001, 32'hCAFE0001, 0,0};
    vecs[6]  = '{1,0,32'hFFFFFFFF, 1,0,32'hFFFFFFFF, 1,0,  0,0,  32'h0,        32'h0,        32'h0,        0,0};
    vecs[7]  = '{0,0,32'h0,        0,0,32'h0,        1,0,  0,0,  32'h0,        32'h0,        32'h0,        0,0};
    vecs[8]  = '{0,0,32'h0,        0,0,32'h0,        1,12, 12,12, 32'h0,       32'h0,        32'h0,        0,0};
    vecs[9]  = '{0,0,32'h0,        0,0,32'h0,        0,0,  12,12, 32'h0,       32'h0,        32'h0,        1,0};
    vecs[10] = '{0,0,32'h0,        0,0,32'h0,        1,12, 12,12, 32'h0,       32'h0,        32'h0,        1,1};
    vecs[11] = '{0,0,32'h0,        0,0,32'h0,        0,0,  12,12, 32'h0,       32'h0,        32'h0,        1,0};
    vecs[12] = '{1,12,32'h000000CC,0,0,32'h0,        1,12, 12,12, 32'h000000CC,32'h0,        32'h0,        0,0};
    vecs[13] = '{0,0,32'h0,        0,0,32'h0,        0,0,  12,12, 32'h000000CC,32'h000000CC, 32'h000000CC, 1,0};
    vecs[14] = '{0,0,32'h0,        1,12,32'h000000DD,0,0,  12,12, 32'h000000DD,32'h000000CC, 32'h000000CC, 0,0};
    vecs[15] = '{0,0,32'h0,        0,0,32'h0,        0,0,  12,12, 32'h000000DD,32'h000000DD, 32'h000000DD, 0,0};
    vecs[16] = '{1,5,32'hDEADBEEF, 0,0,32'h0,        1,20, 5,5,   32'hDEADBEEF,32'h0,        32'h0,        0,0};

    resetn = 1'b0;
    idle_inputs();
    rd_addr = '0;
    test_addr = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      wr0_en = vecs[v].wr0_en; wr0_addr = vecs[v].wr0_addr; wr0_data = vecs[v].wr0_data;
      wr1_en = vecs[v].wr1_en; wr1_addr = vecs[v].wr1_addr; wr1_data = vecs[v].wr1_data;
      iss_en = vecs[v].iss_en; iss_addr = vecs[v].iss_addr;
      rd_addr = {5'd4, 5'd3, 5'd7, vecs[v].rd0};
      test_addr = vecs[v].taddr;
      #1;
      chk($sformatf("vec%0d rd0", v), rd_data[0 +: DW], vecs[v].exp_rd0);
      chk($sformatf("vec%0d rd0_nb", v), rd_data_nb[0 +: DW], vecs[v].exp_rd0_nb);
      chk($sformatf("vec%0d test", v), test_data, vecs[v].exp_test);
      chk($sformatf("vec%0d busy0", v), DW'(rd_busy[0]), DW'(vecs[v].exp_busy0));
      cycle();
      chk($sformatf("vec%0d dbl", v), DW'(dbl_iss), DW'(vecs[v].exp_dbl));
    end

    // Asynchronous reset in the middle of a low clock phase.
    idle_inputs();
    rd_addr = {5'd0, 5'd0, 5'd20, 5'd5};
    test_addr = 5'd5;
    #1;
    chk("pre_rst r5", rd_data[0 +: DW], 32'hDEADBEEF);
    chk("pre_rst busy r20", DW'(rd_busy[1]), 32'h1);
    #1 resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_clear();

    // Write and issue while reset is still low at the edge: both ignored.
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h66666666;
    iss_en = 1'b1; iss_addr = 5'd6;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle_inputs();
    rd_addr = {5'd0, 5'd0, 5'd5, 5'd6};
    test_addr = 5'd6;
    #1;
    chk("rst_edge wr r6", rd_data[0 +: DW], '0);
    chk("rst_edge busy r6", DW'(rd_busy[0]), '0);
    cycle();

    for (int c = 0; c < 10000; c++) begin
      wr0_en = ($urandom_range(0, 1) != 0);
      wr0_addr = raddr();
      wr0_data = $urandom;
      wr1_en = ($urandom_range(0, 2) == 0);
      wr1_addr = raddr();
      wr1_data = $urandom;
      iss_en = ($urandom_range(0, 2) != 0);
      iss_addr = raddr();
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = raddr();
      test_addr = raddr();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
